// File: rtl/lut_word_sequencer_if.sv
// Handshake bundle for lut_word_sequencer: input word stream and mapped word stream.
// slave is the sequencer side, master is the producer/consumer side.
interface lut_word_sequencer_if #(
  parameter int LANES = 4
) ();
  localparam int W = 8 * LANES;

  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_data;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );
endinterface

// File: rtl/lut_word_sequencer.sv
// Serialises a packed word byte by byte onto an 8-bit LUT stage, captures each
// LUT result into the matching output lane and presents the repacked word.
module lut_word_sequencer #(
  parameter int LANES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lut_word_sequencer_if.slave   bus,
  output logic [7:0]            lut_addr,
  input  logic [7:0]            lut_data,
  output logic                  busy
);
  localparam int W     = 8 * LANES;
  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LANES - 1);

  typedef enum logic [1:0] {IDLE, MAP, OUT} state_t;

  state_t           state;
  logic [W-1:0]     sreg;
  logic [W-1:0]     rreg;
  logic [CNT_W-1:0] cnt;
  logic             m_valid_q;
  logic             busy_q;

  // The LUT always sees the low byte of the shift register.
  assign lut_addr    = sreg[7:0];
  // In OUT, s_ready follows m_ready so a new word can be taken on the same
  // edge the mapped word leaves; it never depends on s_valid.
  assign bus.s_ready = (state == IDLE) || ((state == OUT) && bus.m_ready);
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = rreg;
  assign busy        = busy_q;

  // Sequencer FSM: load word, walk lanes through the LUT, hold result until taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      sreg      <= '0;
      rreg      <= '0;
      cnt       <= '0;
      m_valid_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.s_valid) begin
            sreg   <= bus.s_data;
            cnt    <= '0;
            state  <= MAP;
            busy_q <= 1'b1;
          end
        end
        MAP: begin
          rreg[{cnt, 3'b000} +: 8] <= lut_data;
          sreg <= sreg >> 8;
          if (cnt == LAST) begin
            cnt       <= '0;
            state     <= OUT;
            busy_q    <= 1'b0;
            m_valid_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        OUT: begin
          if (bus.m_ready) begin
            m_valid_q <= 1'b0;
            if (bus.s_valid) begin
              sreg   <= bus.s_data;
              cnt    <= '0;
              state  <= MAP;
              busy_q <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          m_valid_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lut_word_sequencer.sv
// Bench for lut_word_sequencer: vector table, directed corner sequences,
// a LANES=2 instance and a randomized run against a queue-based reference.
module tb_lut_word_sequencer;
  localparam int NRAND = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] lut_addr4, lut_data4, lut_addr2, lut_data2;
  logic       busy4, busy2;
  logic [7:0] lut_tab [256];

  lut_word_sequencer_if #(.LANES(4)) if4 ();
  lut_word_sequencer_if #(.LANES(2)) if2 ();

  always_comb lut_data4 = lut_tab[lut_addr4];
  assign lut_data2 = ~lut_addr2;

  lut_word_sequencer #(.LANES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if4),
    .lut_addr(lut_addr4), .lut_data(lut_data4), .busy(busy4)
  );

  lut_word_sequencer #(.LANES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2),
    .lut_addr(lut_addr2), .lut_data(lut_data2), .busy(busy2)
  );

  int          nvec = 0;
  int          nerr = 0;
  int          cyc = 0;
  int          hs_in = 0;
  int          hs_out = 0;
  bit          sb_en = 1'b0;
  logic [31:0] sb_q [$];

  typedef struct {
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;
  vec_t vt [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference mapping: each lane independently looked up in the LUT table.
  function automatic logic [31:0] map_word(input logic [31:0] w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = lut_tab[w[8*i +: 8]];
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Handshake monitor and scoreboard, sampled mid-cycle where signals are settled.
  always @(negedge clk) begin
    if (rst_n) begin
      if (if4.m_valid && if4.m_ready) begin
        hs_out <= hs_out + 1;
        if (sb_en) begin
          if (sb_q.size() == 0) check("sb_unexpected_out", if4.m_data, 32'h0);
          else check("sb_data", if4.m_data, sb_q.pop_front());
        end
      end
      if (if4.s_valid && if4.s_ready) begin
        hs_in <= hs_in + 1;
        if (sb_en) sb_q.push_back(map_word(if4.s_data));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a word and return just after the accept edge with s_valid dropped.
  task automatic send_word(input logic [31:0] din);
    int guard;
    guard = 0;
    if4.s_data  = din;
    if4.s_valid = 1'b1;
    #1;
    while (!if4.s_ready && guard < 20) begin
      step();
      guard++;
    end
    if (guard >= 20) check("accept_timeout", 32'd0, 32'd1);
    step();
    if4.s_valid = 1'b0;
  endtask

  task automatic wait_mvalid();
    int guard;
    guard = 0;
    while (!if4.m_valid && guard < 20) begin
      step();
      guard++;
    end
    if (guard >= 20) check("m_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_vec(input logic [31:0] din, input logic [31:0] exp);
    if4.m_ready = 1'b1;
    send_word(din);
    check("busy_map", busy4, 1'b1);
    check("s_ready_map", if4.s_ready, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("lut_addr_lane", lut_addr4, din[8*i +: 8]);
      check("m_valid_low", if4.m_valid, 1'b0);
      step();
    end
    check("m_valid_high", if4.m_valid, 1'b1);
    check("m_data", if4.m_data, exp);
    step();
    check("m_valid_after_hs", if4.m_valid, 1'b0);
    check("s_ready_idle", if4.s_ready, 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0, i0, t1, t2;
    int guard, gap;
    logic acc;

    vt[0] = '{32'h12345678, 32'hEDCBA987};
    vt[1] = '{32'h00000000, 32'hFFFFFFFF};
    vt[2] = '{32'hFFFFFFFF, 32'h00000000};
    vt[3] = '{32'h01020304, 32'hFEFDFCFB};
    vt[4] = '{32'hAABBCCDD, 32'h55443322};
    vt[5] = '{32'h80FF017F, 32'h7F00FE80};

    for (int i = 0; i < 256; i++) lut_tab[i] = ~8'(i);

    rst_n = 1'b0;
    if4.s_valid = 1'b0; if4.s_data = '0; if4.m_ready = 1'b0;
    if2.s_valid = 1'b0; if2.s_data = '0; if2.m_ready = 1'b0;
    repeat (3) step();
    check("rst_s_ready", if4.s_ready, 1'b1);
    check("rst_m_valid", if4.m_valid, 1'b0);
    check("rst_m_data", if4.m_data, 32'h0);
    check("rst_lut_addr", lut_addr4, 8'h00);
    check("rst_busy", busy4, 1'b0);
    rst_n = 1'b1;
    step();

    // Vector table
    for (int v = 0; v < 6; v++) run_vec(vt[v].din, vt[v].exp);

    // Backpressure: result held while m_ready is low, exactly one handshake on release
    h0 = hs_out;
    if4.m_ready = 1'b0;
    send_word(32'h12345678);
    repeat (4) step();
    check("bp_m_valid", if4.m_valid, 1'b1);
    for (int k = 0; k < 5; k++) begin
      check("bp_m_data_held", if4.m_data, 32'hEDCBA987);
      check("bp_s_ready_low", if4.s_ready, 1'b0);
      check("bp_m_valid_held", if4.m_valid, 1'b1);
      step();
    end
    if4.m_ready = 1'b1;
    #1;
    check("bp_s_ready_pass", if4.s_ready, 1'b1);
    step();
    check("bp_m_valid_drop", if4.m_valid, 1'b0);
    repeat (5) step();
    check("bp_one_handshake", hs_out - h0, 32'd1);

    // Back-to-back with s_valid held: simultaneous handshake path
    if4.m_ready = 1'b1;
    if4.s_data  = 32'h00000000;
    if4.s_valid = 1'b1;
    #1;
    guard = 0;
    while (!if4.s_ready && guard < 20) begin step(); guard++; end
    step();
    if4.s_data = 32'hFFFFFFFF;
    repeat (4) step();
    check("b2b_first_valid", if4.m_valid, 1'b1);
    check("b2b_first_data", if4.m_data, 32'hFFFFFFFF);
    check("b2b_s_ready", if4.s_ready, 1'b1);
    t1 = cyc;
    step();
    if4.s_valid = 1'b0;
    check("b2b_gap_valid", if4.m_valid, 1'b0);
    check("b2b_busy", busy4, 1'b1);
    check("b2b_lut_addr", lut_addr4, 8'hFF);
    wait_mvalid();
    t2 = cyc;
    check("b2b_interval", t2 - t1, 32'd5);
    check("b2b_second_data", if4.m_data, 32'h00000000);
    step();
    check("b2b_done", if4.m_valid, 1'b0);

    // Reset in the middle of MAP discards the word
    send_word(32'hAABBCCDD);
    repeat (2) step();
    check("rmid_lut_lane2", lut_addr4, 8'hBB);
    rst_n = 1'b0;
    step();
    check("rmid_m_valid", if4.m_valid, 1'b0);
    check("rmid_m_data", if4.m_data, 32'h0);
    check("rmid_lut_addr", lut_addr4, 8'h00);
    check("rmid_s_ready", if4.s_ready, 1'b1);
    check("rmid_busy", busy4, 1'b0);
    rst_n = 1'b1;
    repeat (3) step();
    check("rmid_no_output", if4.m_valid, 1'b0);
    run_vec(32'h01020304, 32'hFEFDFCFB);

    // s_valid pulsed during MAP is not accepted
    h0 = hs_out;
    i0 = hs_in;
    if4.m_ready = 1'b1;
    send_word(32'h12345678);
    step();
    if4.s_data  = 32'h11111111;
    if4.s_valid = 1'b1;
    step();
    if4.s_valid = 1'b0;
    wait_mvalid();
    check("ign_m_data", if4.m_data, 32'hEDCBA987);
    repeat (10) step();
    check("ign_in_count", hs_in - i0, 32'd1);
    check("ign_out_count", hs_out - h0, 32'd1);

    // LANES=2 instance
    if2.m_ready = 1'b1;
    if2.s_data  = 16'hA55A;
    if2.s_valid = 1'b1;
    #1;
    check("l2_s_ready", if2.s_ready, 1'b1);
    step();
    if2.s_valid = 1'b0;
    check("l2_lut_lane0", lut_addr2, 8'h5A);
    step();
    check("l2_lut_lane1", lut_addr2, 8'hA5);
    step();
    check("l2_m_valid", if2.m_valid, 1'b1);
    check("l2_m_data", if2.m_data, 16'h5AA5);
    step();
    check("l2_m_valid_drop", if2.m_valid, 1'b0);

    // Randomized run with a random LUT and random backpressure
    for (int i = 0; i < 256; i++) lut_tab[i] = 8'($urandom);
    h0 = hs_out;
    sb_en = 1'b1;
    for (int w = 0; w < NRAND; w++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        if4.m_ready = ($urandom_range(0, 3) != 0);
        step();
      end
      if4.s_data  = $urandom;
      if4.s_valid = 1'b1;
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 50) begin
        if4.m_ready = ($urandom_range(0, 3) != 0);
        #1;
        acc = if4.s_ready;
        step();
        guard++;
      end
      if4.s_valid = 1'b0;
      if (!acc) check("rnd_accept_timeout", 32'd0, 32'd1);
    end
    if4.m_ready = 1'b1;
    guard = 0;
    while (sb_q.size() != 0 && guard < 100) begin step(); guard++; end
    step();
    sb_en = 1'b0;
    check("rnd_drain", sb_q.size(), 32'd0);
    check("rnd_out_count", hs_out - h0, NRAND);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/lut_word_sequencer.md
# lut_word_sequencer

Stream adapter that drives the team's 8-bit LUT mapping stage. Accepts a packed multi-byte word over a valid/ready handshake. Presents its bytes one per cycle to the LUT stage's 8-bit address input and captures each 8-bit LUT result. Emits the repacked mapped word over a second valid/ready handshake. Sits directly upstream of the LUT stage, feeding its input, and also consumes its combinational output.

## Interface
- LANES, default 4: bytes per word (2..16); word width W = 8*LANES.
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- s_valid  input  1  input word valid.
- s_ready  output  1  block can accept an input word.
- s_data  input  W  input word; lane 0 = bits [7:0].
- lut_addr  output  8  byte presented to the LUT stage input; registered.
- lut_data  input  8  LUT stage result for lut_addr; combinational, sampled on the same edge.
- m_valid  output  1  mapped word valid.
- m_ready  input  1  downstream accepts mapped word.
- m_data  output  W  mapped word; lane i = LUT(s_data lane i); registered.
- busy  output  1  high in MAP state.

## Operation
- State machine with states IDLE, MAP, OUT.
- Storage:
  - shift register sreg (W bits);
  - result register rreg (W bits, drives m_data);
  - lane counter cnt (log2 LANES bits, min 1).
- lut_addr = sreg[7:0] at all times.
- IDLE:
  - s_ready=1, m_valid=0.
  - On s_valid&s_ready: sreg<=s_data, cnt<=0, go MAP.
- MAP:
  - s_ready=0, busy=1.
  - Each cycle: rreg lane cnt <= lut_data, sreg <= sreg>>8 with zero fill, cnt<=cnt+1.
  - When cnt==LANES-1, go OUT; cnt wraps to 0.
- OUT:
  - m_valid=1. m_data and rreg are held stable while m_ready=0.
  - s_ready = m_ready, a combinational pass-through permitting overlap.
  - m_ready=1 with s_valid=0: go IDLE.
  - m_ready=1 with s_valid=1: both handshakes complete on the same edge. sreg<=s_data, cnt<=0, go MAP directly; rreg is overwritten lane by lane from the next cycle.
- Input is never accepted in MAP. s_data is ignored when no handshake occurs.
- Lanes are written individually. Lanes of rreg not yet rewritten in a new pass keep their old values, but m_valid=0 throughout MAP.
- Reset (rst_n=0 on an edge), taking priority in any state including mid-MAP:
  - state<=IDLE, sreg<=0, rreg<=0, cnt<=0.
  - The in-flight word is discarded with no partial output.
  - Outputs after reset: s_ready=1, m_valid=0, m_data=0, lut_addr=0x00, busy=0.
- No arithmetic beyond the counter. Byte order is preserved: output lane i always corresponds to input lane i.

## Timing
- Input accept edge E0. Lane i is on lut_addr during the cycle after edge E0+i and captured at edge E0+i+1.
- m_valid rises after edge E0+LANES, a latency of LANES cycles from the accept edge.
- Output handshake edge Ek ≥ E0+LANES. With s_valid high at Ek, the next m_valid rises after Ek+LANES.
- Minimum issue interval LANES+1 cycles. Throughput is one word per LANES+1 cycles when m_ready is held high.
- LUT stage path: sreg → lut_addr → LUT → lut_data → rreg is single-cycle combinational and must meet clk period.
- s_ready depends combinationally on m_ready in OUT only. There is no combinational path from s_valid to s_ready or m_valid.

## Test plan
Bench models the LUT as lut_data = ~lut_addr.
- Reset then single word: s_data=0x12345678, m_ready=1.
  - lut_addr sequence: 0x78, 0x56, 0x34, 0x12.
  - m_valid rises 4 cycles after accept with m_data=0xEDCBA987.
  - Returns to IDLE with s_ready=1.
- Backpressure: m_ready=0 for 5 cycles after m_valid.
  - m_data is held at 0xEDCBA987 and s_ready=0.
  - Releasing m_ready gives exactly one output handshake.
- Back-to-back: s_valid held, words 0x00000000 then 0xFFFFFFFF, m_ready=1.
  - Outputs 0xFFFFFFFF then 0x00000000.
  - Second m_valid rises exactly 5 cycles after the first (simultaneous handshake path).
- Reset mid-MAP: rst_n=0 at lane 2 of 0xAABBCCDD.
  - Next cycle: m_valid=0, m_data=0, lut_addr=0, s_ready=1, busy=0.
  - The next word 0x01020304 yields 0xFEFDFCFB.
- s_valid pulsed while busy is ignored: word 0x11111111 offered during MAP is not accepted, and only the first word's result appears.
- LANES=2 build: s_data=0xA55A → lut_addr 0x5A, 0xA5 → m_data=0x5AA5 after 2 cycles.
